// File: rtl/core_mem_s.sv
// Memory stage of the Selen core: issues L1D loads/stores, aligns and extends load data, registers MEM/WB.
// Optional misaligned-access trap is enabled by defining CORE_MEM_MISALIGN_CHK_EN.
module core_mem_s (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_enb,
    input  logic        mem_val_inst_in,
    input  logic        mem_we_reg_file_in,
    input  logic [2:0]  mem_wb_sx_op_in,
    input  logic        mem_mux_alu_mem_in,
    input  logic        mem_l1d_val_in,
    input  logic        mem_l1d_cop_in,
    input  logic [2:0]  mem_l1d_size_in,
    input  logic [31:0] mem_addr_in,
    input  logic [31:0] mem_wrt_data_in,
    input  logic [31:0] mem_alu_result_in,
    input  logic [4:0]  mem_rd_in,
    output logic        l1d_req_val,
    input  logic        l1d_req_rdy,
    output logic        l1d_req_cop,
    output logic [31:0] l1d_req_addr,
    output logic [3:0]  l1d_req_be,
    output logic [31:0] l1d_req_wdata,
    input  logic        l1d_resp_val,
    input  logic [31:0] l1d_resp_rdata,
    output logic        mem_stall_out,
    output logic        mem_misalign_out,
    output logic [31:0] mem2exe_result_out,
    output logic [4:0]  mem2haz_rd_out,
    output logic        mem2haz_we_out,
    output logic [31:0] mem_wb_data_out_reg,
    output logic [4:0]  mem_rd_out_reg,
    output logic        mem_we_reg_file_out_reg,
    output logic        mem_val_inst_out_reg
);

    typedef enum logic {IDLE, WAIT_RESP} state_t;

    state_t      state_q, state_d;
    logic        misaligned;
    logic        req_val;
    logic        stall;
    logic [31:0] wb_data_d;
    logic [31:0] wb_data_q;
    logic [4:0]  rd_q;
    logic        we_q;
    logic        val_q;

    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] a);
        if (size[0])      return 4'b0001 << a;
        else if (size[1]) return 4'b0011 << {a[1], 1'b0};
        else              return 4'b1111;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] size, input logic [31:0] d);
        if (size[0])      return {4{d[7:0]}};
        else if (size[1]) return {2{d[15:0]}};
        else              return d;
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] sx, input logic [1:0] a,
                                             input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(rdata >> {a, 3'b000});
        h = 16'(rdata >> {a[1], 4'b0000});
        case (sx)
            3'b001:  return {{24{b[7]}}, b};
            3'b010:  return {24'h0, b};
            3'b011:  return {{16{h[15]}}, h};
            3'b100:  return {16'h0, h};
            default: return rdata;
        endcase
    endfunction

`ifdef CORE_MEM_MISALIGN_CHK_EN
    assign misaligned = mem_l1d_val_in & mem_val_inst_in &
                        ((mem_l1d_size_in[1] & mem_addr_in[0]) |
                         (mem_l1d_size_in[2] & (|mem_addr_in[1:0])));
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // A store finishes on acceptance; a load waits for the response pulse.
    always_comb begin
        state_d = state_q;
        req_val = 1'b0;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                req_val = mem_l1d_val_in & mem_val_inst_in & ~misaligned;
                stall   = req_val & ~(mem_l1d_cop_in & l1d_req_rdy);
                if (req_val & l1d_req_rdy & ~mem_l1d_cop_in) state_d = WAIT_RESP;
            end
            WAIT_RESP: begin
                stall = ~l1d_resp_val;
                if (l1d_resp_val) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign l1d_req_val   = req_val;
    assign l1d_req_cop   = mem_l1d_cop_in;
    assign l1d_req_addr  = {mem_addr_in[31:2], 2'b00};
    assign l1d_req_be    = byte_en(mem_l1d_size_in, mem_addr_in[1:0]);
    assign l1d_req_wdata = store_lanes(mem_l1d_size_in, mem_wrt_data_in);

    assign mem_stall_out      = stall;
    assign mem_misalign_out   = misaligned;
    assign mem2exe_result_out = mem_alu_result_in;
    assign mem2haz_rd_out     = mem_rd_in;
    assign mem2haz_we_out     = mem_we_reg_file_in;

    assign wb_data_d = mem_mux_alu_mem_in
                     ? load_ext(mem_wb_sx_op_in, mem_addr_in[1:0], l1d_resp_rdata)
                     : mem_alu_result_in;

    // MEM/WB register boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_data_q <= 32'h0;
            rd_q      <= 5'h0;
            we_q      <= 1'b0;
            val_q     <= 1'b0;
        end else if (mem_enb & ~stall) begin
            wb_data_q <= wb_data_d;
            rd_q      <= mem_rd_in;
            we_q      <= mem_we_reg_file_in & ~misaligned;
            val_q     <= mem_val_inst_in & ~misaligned;
        end
    end

    assign mem_wb_data_out_reg     = wb_data_q;
    assign mem_rd_out_reg          = rd_q;
    assign mem_we_reg_file_out_reg = we_q;
    assign mem_val_inst_out_reg    = val_q;

endmodule

// File: tb/tb_core_mem_s.sv
// Directed bench for core_mem_s: request-side checks inline, write-back results via a scoreboard monitor.
module tb_core_mem_s;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_enb;
    logic        mem_val_inst_in;
    logic        mem_we_reg_file_in;
    logic [2:0]  mem_wb_sx_op_in;
    logic        mem_mux_alu_mem_in;
    logic        mem_l1d_val_in;
    logic        mem_l1d_cop_in;
    logic [2:0]  mem_l1d_size_in;
    logic [31:0] mem_addr_in;
    logic [31:0] mem_wrt_data_in;
    logic [31:0] mem_alu_result_in;
    logic [4:0]  mem_rd_in;
    logic        l1d_req_val;
    logic        l1d_req_rdy;
    logic        l1d_req_cop;
    logic [31:0] l1d_req_addr;
    logic [3:0]  l1d_req_be;
    logic [31:0] l1d_req_wdata;
    logic        l1d_resp_val;
    logic [31:0] l1d_resp_rdata;
    logic        mem_stall_out;
    logic        mem_misalign_out;
    logic [31:0] mem2exe_result_out;
    logic [4:0]  mem2haz_rd_out;
    logic        mem2haz_we_out;
    logic [31:0] mem_wb_data_out_reg;
    logic [4:0]  mem_rd_out_reg;
    logic        mem_we_reg_file_out_reg;
    logic        mem_val_inst_out_reg;

    core_mem_s dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .mem_enb                 (mem_enb),
        .mem_val_inst_in         (mem_val_inst_in),
        .mem_we_reg_file_in      (mem_we_reg_file_in),
        .mem_wb_sx_op_in         (mem_wb_sx_op_in),
        .mem_mux_alu_mem_in      (mem_mux_alu_mem_in),
        .mem_l1d_val_in          (mem_l1d_val_in),
        .mem_l1d_cop_in          (mem_l1d_cop_in),
        .mem_l1d_size_in         (mem_l1d_size_in),
        .mem_addr_in             (mem_addr_in),
        .mem_wrt_data_in         (mem_wrt_data_in),
        .mem_alu_result_in       (mem_alu_result_in),
        .mem_rd_in               (mem_rd_in),
        .l1d_req_val             (l1d_req_val),
        .l1d_req_rdy             (l1d_req_rdy),
        .l1d_req_cop             (l1d_req_cop),
        .l1d_req_addr            (l1d_req_addr),
        .l1d_req_be              (l1d_req_be),
        .l1d_req_wdata           (l1d_req_wdata),
        .l1d_resp_val            (l1d_resp_val),
        .l1d_resp_rdata          (l1d_resp_rdata),
        .mem_stall_out           (mem_stall_out),
        .mem_misalign_out        (mem_misalign_out),
        .mem2exe_result_out      (mem2exe_result_out),
        .mem2haz_rd_out          (mem2haz_rd_out),
        .mem2haz_we_out          (mem2haz_we_out),
        .mem_wb_data_out_reg     (mem_wb_data_out_reg),
        .mem_rd_out_reg          (mem_rd_out_reg),
        .mem_we_reg_file_out_reg (mem_we_reg_file_out_reg),
        .mem_val_inst_out_reg    (mem_val_inst_out_reg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic push_exp(input logic [31:0] d, input logic [4:0] rd, input logic we);
        exp_t e;
        e.data = d;
        e.rd   = rd;
        e.we   = we;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bubble();
        mem_val_inst_in    = 1'b0;
        mem_we_reg_file_in = 1'b0;
        mem_wb_sx_op_in    = 3'b000;
        mem_mux_alu_mem_in = 1'b0;
        mem_l1d_val_in     = 1'b0;
        mem_l1d_cop_in     = 1'b0;
        mem_l1d_size_in    = 3'b100;
        mem_addr_in        = 32'h0;
        mem_wrt_data_in    = 32'h0;
        mem_alu_result_in  = 32'h0;
        mem_rd_in          = 5'h0;
        l1d_req_rdy        = 1'b0;
        l1d_resp_val       = 1'b0;
        l1d_resp_rdata     = 32'h0;
    endtask

    task automatic issue(input logic cop, input logic [2:0] size, input logic [2:0] sx,
                         input logic mux, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] alu, input logic [4:0] rd, input logic we);
        mem_val_inst_in    = 1'b1;
        mem_l1d_val_in     = 1'b1;
        mem_l1d_cop_in     = cop;
        mem_l1d_size_in    = size;
        mem_wb_sx_op_in    = sx;
        mem_mux_alu_mem_in = mux;
        mem_addr_in        = addr;
        mem_wrt_data_in    = wd;
        mem_alu_result_in  = alu;
        mem_rd_in          = rd;
        mem_we_reg_file_in = we;
    endtask

    // Every completed instruction shows val_out for exactly one cycle because bubbles separate them.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && mem_val_inst_out_reg === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wb_unexpected actual_data=%h required=none", mem_wb_data_out_reg);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wb_data", mem_wb_data_out_reg, e.data);
                chk("wb_rd", 32'(mem_rd_out_reg), 32'(e.rd));
                chk("wb_we", 32'(mem_we_reg_file_out_reg), 32'(e.we));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        mem_enb = 1'b1;
        bubble();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wb_data", mem_wb_data_out_reg, 32'h0);
        chk("rst_val", 32'(mem_val_inst_out_reg), 32'h0);
        chk("rst_we", 32'(mem_we_reg_file_out_reg), 32'h0);
        chk("rst_stall", 32'(mem_stall_out), 32'h0);
        chk("rst_req_val", 32'(l1d_req_val), 32'h0);
        rst_n = 1'b1;
        step();

        // ALU op with a stray response pulse that must be ignored in IDLE
        mem_val_inst_in    = 1'b1;
        mem_we_reg_file_in = 1'b1;
        mem_rd_in          = 5'd5;
        mem_alu_result_in  = 32'h0000_1234;
        l1d_resp_val       = 1'b1;
        l1d_resp_rdata     = 32'hDEAD_BEEF;
        push_exp(32'h0000_1234, 5'd5, 1'b1);
        @(negedge clk);
        chk("alu_stall", 32'(mem_stall_out), 32'h0);
        chk("alu_req_val", 32'(l1d_req_val), 32'h0);
        chk("alu_fwd", mem2exe_result_out, 32'h0000_1234);
        step();
        bubble();
        step();

        // Store byte 0xAB at offset 2
        issue(1'b1, 3'b001, 3'b000, 1'b0, 32'h0000_1002, 32'h1234_56AB, 32'h0000_1002, 5'd0, 1'b0);
        l1d_req_rdy = 1'b1;
        push_exp(32'h0000_1002, 5'd0, 1'b0);
        @(negedge clk);
        chk("sb_req_val", 32'(l1d_req_val), 32'h1);
        chk("sb_be", 32'(l1d_req_be), 32'h4);
        chk("sb_wdata", l1d_req_wdata, 32'hABAB_ABAB);
        chk("sb_addr", l1d_req_addr, 32'h0000_1000);
        chk("sb_cop", 32'(l1d_req_cop), 32'h1);
        chk("sb_stall", 32'(mem_stall_out), 32'h0);
        step();
        bubble();
        step();

        // Store half 0xBEEF at offset 2, cache not ready for one cycle
        issue(1'b1, 3'b010, 3'b000, 1'b0, 32'h0000_1102, 32'h0000_BEEF, 32'h0000_0077, 5'd0, 1'b0);
        push_exp(32'h0000_0077, 5'd0, 1'b0);
        @(negedge clk);
        chk("sh_wait_stall", 32'(mem_stall_out), 32'h1);
        chk("sh_be", 32'(l1d_req_be), 32'hC);
        chk("sh_wdata", l1d_req_wdata, 32'hBEEF_BEEF);
        step();
        l1d_req_rdy = 1'b1;
        @(negedge clk);
        chk("sh_acc_stall", 32'(mem_stall_out), 32'h0);
        step();
        bubble();
        step();

        // Load sbyte at offset 3, response one cycle after accept
        issue(1'b0, 3'b001, 3'b001, 1'b1, 32'h0000_2003, 32'h0, 32'h0000_2003, 5'd7, 1'b1);
        l1d_req_rdy = 1'b1;
        push_exp(32'hFFFF_FF80, 5'd7, 1'b1);
        @(negedge clk);
        chk("lb_req_val", 32'(l1d_req_val), 32'h1);
        chk("lb_be", 32'(l1d_req_be), 32'h8);
        chk("lb_acc_stall", 32'(mem_stall_out), 32'h1);
        step();
        l1d_req_rdy    = 1'b0;
        l1d_resp_val   = 1'b1;
        l1d_resp_rdata = 32'h8000_0000;
        @(negedge clk);
        chk("lb_resp_stall", 32'(mem_stall_out), 32'h0);
        chk("lb_resp_req_val", 32'(l1d_req_val), 32'h0);
        step();
        bubble();
        step();

        // Load uhalf at offset 2: two cycles without rdy, response three cycles after accept
        issue(1'b0, 3'b010, 3'b100, 1'b1, 32'h0000_3002, 32'h0, 32'h0, 5'd9, 1'b1);
        push_exp(32'h0000_8001, 5'd9, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("lh_nordy_stall", 32'(mem_stall_out), 32'h1);
            chk("lh_nordy_req_val", 32'(l1d_req_val), 32'h1);
            step();
        end
        l1d_req_rdy = 1'b1;
        @(negedge clk);
        chk("lh_acc_stall", 32'(mem_stall_out), 32'h1);
        chk("lh_be", 32'(l1d_req_be), 32'hC);
        step();
        l1d_req_rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("lh_wait_stall", 32'(mem_stall_out), 32'h1);
            chk("lh_wait_req_val", 32'(l1d_req_val), 32'h0);
            step();
        end
        l1d_resp_val   = 1'b1;
        l1d_resp_rdata = 32'h8001_0000;
        @(negedge clk);
        chk("lh_resp_stall", 32'(mem_stall_out), 32'h0);
        step();
        bubble();
        step();

        // Store word to a misaligned address
        issue(1'b1, 3'b100, 3'b000, 1'b0, 32'h0000_4001, 32'hDEAD_BEEF, 32'h0000_0055, 5'd4, 1'b1);
        l1d_req_rdy = 1'b1;
`ifdef CORE_MEM_MISALIGN_CHK_EN
        @(negedge clk);
        chk("mis_flag", 32'(mem_misalign_out), 32'h1);
        chk("mis_req_val", 32'(l1d_req_val), 32'h0);
        chk("mis_stall", 32'(mem_stall_out), 32'h0);
        step();
        @(negedge clk);
        chk("mis_val_out", 32'(mem_val_inst_out_reg), 32'h0);
        chk("mis_we_out", 32'(mem_we_reg_file_out_reg), 32'h0);
        chk("mis_wb_data", mem_wb_data_out_reg, 32'h0000_0055);
`else
        push_exp(32'h0000_0055, 5'd4, 1'b1);
        @(negedge clk);
        chk("mis_flag", 32'(mem_misalign_out), 32'h0);
        chk("mis_req_val", 32'(l1d_req_val), 32'h1);
        chk("mis_be", 32'(l1d_req_be), 32'hF);
        chk("mis_addr", l1d_req_addr, 32'h0000_4000);
        chk("mis_wdata", l1d_req_wdata, 32'hDEAD_BEEF);
        step();
`endif
        bubble();
        step();

        // Reset while waiting for a load response; the late response must be dropped
        issue(1'b0, 3'b100, 3'b000, 1'b1, 32'h0000_5000, 32'h0, 32'h0, 5'd3, 1'b1);
        l1d_req_rdy = 1'b1;
        step();
        l1d_req_rdy = 1'b0;
        @(negedge clk);
        chk("rstw_wait_stall", 32'(mem_stall_out), 32'h1);
        rst_n = 1'b0;
        bubble();
        #1;
        chk("rstw_async_stall", 32'(mem_stall_out), 32'h0);
        step();
        rst_n = 1'b1;
        l1d_resp_val   = 1'b1;
        l1d_resp_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("rstw_resp_stall", 32'(mem_stall_out), 32'h0);
        chk("rstw_req_val", 32'(l1d_req_val), 32'h0);
        step();
        l1d_resp_val = 1'b0;
        @(negedge clk);
        chk("rstw_wb_data", mem_wb_data_out_reg, 32'h0);
        chk("rstw_val", 32'(mem_val_inst_out_reg), 32'h0);
        chk("rstw_we", 32'(mem_we_reg_file_out_reg), 32'h0);
        chk("rstw_rd", 32'(mem_rd_out_reg), 32'h0);
        step();
        step();

        chk("sb_queue_empty", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
